vh_sync_rx: RTL and testbench



---
 rtl/vh_sync_pkg.sv | 35 +++
 rtl/vh_edge_det.sv | 39 +++
 rtl/vh_sync_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_vh_sync_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vh_sync_pkg.sv
// -----------------------------------------------------------------------------
// vh_sync_pkg
// Shared definitions for the VSYNC/HSYNC receive path:
//   CW           - width of the X/Y/geometry counters
//   CNT_MAX      - saturation value of those counters
//   H_WIDTH_DEF  - default expected active pixels per line
//   V_WIDTH_DEF  - default expected active lines per frame
//   state_e      - frame-tracking FSM states
//   sat_inc()    - saturating increment used by the coordinate counters
// -----------------------------------------------------------------------------
package vh_sync_pkg;

  localparam int CW          = 13;
  localparam int H_WIDTH_DEF = 2448;
  localparam int V_WIDTH_DEF = 2048;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // IDLE   : after reset/enable, waiting to see VSYNC low so that a frame
  //          already in progress is never captured half-way.
  // WAIT   : VSYNC low, waiting for the next VSYNC rise.
  // ACTIVE : inside a frame, pixels are accepted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Counters stick at their maximum instead of wrapping, so an oversized
  // line or frame never aliases back onto small coordinates.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vh_edge_det.sv
// -----------------------------------------------------------------------------
// vh_edge_det
// Stage-1 register for one level-type sync signal plus edge flags computed
// against the raw (not yet registered) input, giving one cycle of lookahead.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   en_i     in   low = register held cleared
//   sig_i    in   raw level input
//   sig_q_o  out  registered level (stage 1)
//   rise_o   out  stage 1 low, raw input high
//   fall_o   out  stage 1 high, raw input low
// -----------------------------------------------------------------------------
module vh_edge_det
  import vh_sync_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sig_i,
  output logic sig_q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign sig_q_o = sig_q;
  assign rise_o  = ~sig_q &  sig_i;
  assign fall_o  =  sig_q & ~sig_i;

endmodule

// File: rtl/vh_sync_rx.sv
// -----------------------------------------------------------------------------
// vh_sync_rx
// Receive side of the VSYNC/HSYNC timing generator. Turns level-type VSYNC
// (high during active lines) and HSYNC (high during active pixels) into
// per-pixel coordinates, frame/line markers, measured geometry and
// protocol-error pulses.
//
// Parameters
//   H_WIDTH   expected active pixels per line
//   V_WIDTH   expected active lines per frame
//   DW        pixel data width
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            low = synchronous clear, same effect as rst
//   vsync_in          vertical active level
//   hsync_in          horizontal active level (pixel valid)
//   data_in           pixel data aligned with hsync_in
//   pix_valid         accepted active pixel
//   pix_data          pixel data (2-cycle latency)
//   pix_x, pix_y      0-based coordinates of pix_data
//   sof               first pixel of a frame
//   eol               last pixel of a line
//   eof               one-cycle pulse at VSYNC falling edge
//   frame_cnt         completed frames, wraps 15 -> 0
//   meas_w            pixel count of the last completed line
//   meas_h            line count of the last completed frame
//   err_hlen          line length differed from H_WIDTH (with eol)
//   err_vlen          frame height differed from V_WIDTH (with eof)
//   err_sync          HSYNC seen while VSYNC low; pixel dropped
// -----------------------------------------------------------------------------
module vh_sync_rx
  import vh_sync_pkg::*;
#(
  parameter int H_WIDTH = H_WIDTH_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF,
  parameter int DW      = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          vsync_in,
  input  logic          hsync_in,
  input  logic [DW-1:0] data_in,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic [3:0]    frame_cnt,
  output logic [CW-1:0] meas_w,
  output logic [CW-1:0] meas_h,
  output logic          err_hlen,
  output logic          err_vlen,
  output logic          err_sync
);

  // ---------------------------------------------------------------------------
  // Stage 1: registered sync levels with raw-input edge lookahead
  // ---------------------------------------------------------------------------
  logic s1_v;
  logic s1_h;
  logic v_rise;
  logic v_fall;
  logic h_rise;
  logic h_fall;

  vh_edge_det u_vsync_det (
    .clk     (clk),
    .rst     (rst),
    .en_i    (enable),
    .sig_i   (vsync_in),
    .sig_q_o (s1_v),
    .rise_o  (v_rise),
    .fall_o  (v_fall)
  );

  vh_edge_det u_hsync_det (
    .clk     (clk),
    .rst     (rst),
    .en_i    (enable),
    .sig_i   (hsync_in),
    .sig_q_o (s1_h),
    .rise_o  (h_rise),
    .fall_o  (h_fall)
  );

  logic [DW-1:0] s1_d_q;
  // Stage 1 holds real samples only from the second cycle after a clear;
  // before that s1_v=0 is just the cleared value, not an observed VSYNC low.
  logic          s1_vld_q;

  // ---------------------------------------------------------------------------
  // Output stage state
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [3:0]    frame_cnt_q;
  logic [CW-1:0] meas_w_q;
  logic [CW-1:0] meas_h_q;
  logic          pix_valid_q;
  logic [DW-1:0] pix_data_q;
  logic [CW-1:0] pix_x_q;
  logic [CW-1:0] pix_y_q;
  logic          sof_q;
  logic          eol_q;
  logic          eof_q;
  logic          err_hlen_q;
  logic          err_vlen_q;
  logic          err_sync_q;

  logic [CW-1:0] x_inc;
  logic [CW-1:0] y_inc;
  logic [CW-1:0] y_end;

  assign x_inc = sat_inc(x_q);
  assign y_inc = sat_inc(y_q);
  // When HSYNC and VSYNC fall together the closing line is still counted.
  assign y_end = h_fall ? y_inc : y_q;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q     <= ST_IDLE;
      s1_d_q      <= '0;
      s1_vld_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      meas_w_q    <= '0;
      meas_h_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_hlen_q  <= 1'b0;
      err_vlen_q  <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      s1_d_q      <= data_in;
      s1_vld_q    <= 1'b1;

      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_hlen_q  <= 1'b0;
      err_vlen_q  <= 1'b0;
      err_sync_q  <= s1_h & ~s1_v;

      case (state_q)
        ST_IDLE: begin
          // Leave only after a genuinely sampled VSYNC low. If VSYNC is
          // already rising again (1-cycle gap) go straight to ACTIVE so the
          // frame that starts now is not lost.
          if (s1_vld_q && !s1_v) begin
            state_q <= vsync_in ? ST_ACTIVE : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (v_rise) begin
            state_q <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // A new line always starts at column 0.
          if (h_rise) begin
            x_q <= '0;
          end

          if (s1_h) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= s1_d_q;
            pix_x_q     <= x_q;
            pix_y_q     <= y_q;
            // y only returns to 0 at eof, so (0,0) is the first pixel.
            sof_q       <= (x_q == '0) && (y_q == '0);
            if (h_fall) begin
              eol_q      <= 1'b1;
              meas_w_q   <= x_inc;
              err_hlen_q <= (x_inc != CW'(H_WIDTH));
              x_q        <= '0;
              y_q        <= y_inc;
            end else begin
              x_q <= x_inc;
            end
          end

          if (v_fall) begin
            eof_q       <= 1'b1;
            meas_h_q    <= y_end;
            err_vlen_q  <= (y_end != CW'(V_WIDTH));
            frame_cnt_q <= frame_cnt_q + 4'd1;
            x_q         <= '0;
            y_q         <= '0;
            state_q     <= ST_WAIT;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign frame_cnt = frame_cnt_q;
  assign meas_w    = meas_w_q;
  assign meas_h    = meas_h_q;
  assign err_hlen  = err_hlen_q;
  assign err_vlen  = err_vlen_q;
  assign err_sync  = err_sync_q;

endmodule

// File: tb/tb_vh_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_vh_sync_rx
// Drives small frames (8x4, HBLK=4) and scores every accepted pixel and every
// end-of-frame against expectations queued when the stimulus was driven.
// -----------------------------------------------------------------------------
module tb_vh_sync_rx;

  localparam int H_W  = 8;
  localparam int V_W  = 4;
  localparam int DW   = 24;
  localparam int HBLK = 4;
  localparam int VBLK = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          vsync_in;
  logic          hsync_in;
  logic [DW-1:0] data_in;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [12:0]   pix_x;
  logic [12:0]   pix_y;
  logic          sof;
  logic          eol;
  logic          eof;
  logic [3:0]    frame_cnt;
  logic [12:0]   meas_w;
  logic [12:0]   meas_h;
  logic          err_hlen;
  logic          err_vlen;
  logic          err_sync;

  vh_sync_rx #(
    .H_WIDTH (H_W),
    .V_WIDTH (V_W),
    .DW      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .vsync_in  (vsync_in),
    .hsync_in  (hsync_in),
    .data_in   (data_in),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .frame_cnt (frame_cnt),
    .meas_w    (meas_w),
    .meas_h    (meas_h),
    .err_hlen  (err_hlen),
    .err_vlen  (err_vlen),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [12:0]   x;
    logic [12:0]   y;
    logic          sof;
    logic          eol;
    logic [12:0]   mw;
    logic          hl;
  } pix_t;

  typedef struct {
    logic [12:0] mh;
    logic        vl;
    logic [3:0]  fc;
  } ev_t;

  pix_t pix_q[$];
  ev_t  ev_q[$];
  pix_t mon_e;
  ev_t  mon_ev;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_sync = 0;
  int n_pix  = 0;
  int fc     = 0;
  bit mon_off = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!mon_off) begin
      if (err_sync) n_sync++;
      if (pix_valid) begin
        n_pix++;
        if (pix_q.size() == 0) begin
          chk("pix_unexpected", 32'(pix_valid), 32'd0);
        end else begin
          mon_e = pix_q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(mon_e.data));
          chk("pix_x",    32'(pix_x),    32'(mon_e.x));
          chk("pix_y",    32'(pix_y),    32'(mon_e.y));
          chk("sof",      32'(sof),      32'(mon_e.sof));
          chk("eol",      32'(eol),      32'(mon_e.eol));
          chk("err_hlen", 32'(err_hlen), 32'(mon_e.hl));
          if (mon_e.eol) chk("meas_w", 32'(meas_w), 32'(mon_e.mw));
        end
      end else if (sof || eol || err_hlen) begin
        chk("marker_no_pix", 32'({sof, eol, err_hlen}), 32'd0);
      end
      if (eof) begin
        if (ev_q.size() == 0) begin
          chk("eof_unexpected", 32'(eof), 32'd0);
        end else begin
          mon_ev = ev_q.pop_front();
          chk("meas_h",    32'(meas_h),    32'(mon_ev.mh));
          chk("err_vlen",  32'(err_vlen),  32'(mon_ev.vl));
          chk("frame_cnt", 32'(frame_cnt), 32'(mon_ev.fc));
          $display("eof: frame_cnt=%0d meas_h=%0d err_vlen=%0d", frame_cnt, meas_h, err_vlen);
        end
      end else if (err_vlen) begin
        chk("vlen_no_eof", 32'(err_vlen), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic [DW-1:0] d);
    @(negedge clk);
    vsync_in = v;
    hsync_in = h;
    data_in  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  // Lines of pixels then HBLK; VSYNC drops after the last line (optionally
  // together with HSYNC when tail_blank=0), followed by vblk low cycles.
  task automatic send_frame(input int nlines, input int short_idx, input int short_len,
                            input bit tail_blank, input int vblk, input bit capture);
    int            len;
    pix_t          e;
    ev_t           ev;
    logic [DW-1:0] d;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_idx) ? short_len : H_W;
      for (int p = 0; p < len; p++) begin
        d = DW'($urandom);
        drive(1'b1, 1'b1, d);
        if (capture) begin
          e.data = d;
          e.x    = 13'(p);
          e.y    = 13'(l);
          e.sof  = (l == 0) && (p == 0);
          e.eol  = (p == len - 1);
          e.mw   = 13'(len);
          e.hl   = (p == len - 1) && (len != H_W);
          pix_q.push_back(e);
        end
      end
      if (l != nlines - 1 || tail_blank) repeat (HBLK) drive(1'b1, 1'b0, '0);
    end
    if (capture) begin
      fc    = (fc + 1) % 16;
      ev.mh = 13'(nlines);
      ev.vl = (nlines != V_W);
      ev.fc = 4'(fc);
      ev_q.push_back(ev);
    end
    repeat (vblk) drive(1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pix_q.size() != 0 || ev_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(pix_q.size() + ev_q.size()), 32'd0);
    pix_q.delete();
    ev_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 32'({pix_valid, sof, eol, eof, err_hlen, err_vlen, err_sync}), 32'd0);
    chk({tag, "_data"},  32'(pix_data), 32'd0);
    chk({tag, "_xy"},    32'({pix_x, pix_y}), 32'd0);
    chk({tag, "_meas"},  32'({meas_w, meas_h}), 32'd0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(4);

    // Nominal 8x4 frame
    send_frame(V_W, -1, 0, 1'b1, VBLK, 1'b1);
    drain("nominal_drain");
    chk("nominal_pix_count", 32'(n_pix), 32'd32);

    // Line 2 shortened to 7 pixels
    send_frame(V_W, 2, 7, 1'b1, VBLK, 1'b1);
    drain("short_line_drain");

    // Three-line frame
    send_frame(3, -1, 0, 1'b1, VBLK, 1'b1);
    drain("three_lines_drain");

    // HSYNC and VSYNC fall together: eol and eof coincide
    send_frame(V_W, -1, 0, 1'b0, VBLK, 1'b1);
    drain("together_drain");

    // HSYNC pulse while VSYNC low
    drive(1'b0, 1'b1, DW'($urandom));
    drive(1'b0, 1'b1, DW'($urandom));
    idle(4);
    chk("err_sync_pulse", 32'(n_sync), 32'd2);

    // enable dropped mid-line, raised again mid-frame
    mon_off = 1'b1;
    repeat (H_W) drive(1'b1, 1'b1, DW'($urandom));
    repeat (HBLK) drive(1'b1, 1'b0, '0);
    repeat (4) drive(1'b1, 1'b1, DW'($urandom));
    enable = 1'b0;
    @(negedge clk);
    check_zero("enable_low");
    mon_off = 1'b0;
    fc = 0;
    repeat (4) drive(1'b1, 1'b1, DW'($urandom));
    repeat (HBLK) drive(1'b1, 1'b0, '0);
    enable = 1'b1;
    send_frame(2, -1, 0, 1'b1, VBLK, 1'b0);
    send_frame(V_W, -1, 0, 1'b1, VBLK, 1'b1);
    drain("after_enable_drain");

    // rst asserted mid-line
    mon_off = 1'b1;
    repeat (H_W) drive(1'b1, 1'b1, DW'($urandom));
    repeat (HBLK) drive(1'b1, 1'b0, '0);
    repeat (3) drive(1'b1, 1'b1, DW'($urandom));
    rst = 1'b1;
    drive(1'b1, 1'b1, DW'($urandom));
    check_zero("mid_reset");
    rst = 1'b0;
    mon_off = 1'b0;
    fc = 0;
    repeat (4) drive(1'b1, 1'b1, DW'($urandom));
    repeat (HBLK) drive(1'b1, 1'b0, '0);
    send_frame(2, -1, 0, 1'b1, VBLK, 1'b0);
    send_frame(V_W, -1, 0, 1'b1, VBLK, 1'b1);
    drain("after_reset_drain");

    // 16 back-to-back frames with a 1-cycle VSYNC gap: frame_cnt wraps
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fc = 0;
    idle(4);
    repeat (16) send_frame(V_W, -1, 0, 1'b1, 1, 1'b1);
    drain("wrap_drain");
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    chk("err_sync_total", 32'(n_sync), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
